// File: rtl/fb_ddr_burst_reader.sv
// Avalon-MM burst-read master: fetches one framebuffer from DDR into a show-ahead
// pixel FIFO, issuing a burst only when the FIFO can absorb all of it.
module fb_ddr_burst_reader #(
    parameter int unsigned BURST_LEN   = 64,
    parameter int unsigned FRAME_WORDS = 307200,
    parameter int unsigned FIFO_DEPTH  = 256
) (
    input  logic                          clk_clk,
    input  logic                          reset,
    input  logic [29:0]                   start_address,
    input  logic                          frame_start,
    output logic                          busy,
    output logic                          frame_done,
    output logic [29:0]                   ddr_address,
    output logic [7:0]                    ddr_burstcount,
    output logic                          ddr_read,
    output logic                          ddr_write,
    output logic [31:0]                   ddr_writedata,
    output logic [3:0]                    ddr_byteenable,
    input  logic                          ddr_waitrequest,
    input  logic [31:0]                   ddr_readdata,
    input  logic                          ddr_readdatavalid,
    output logic [31:0]                   pix_data,
    output logic                          pix_valid,
    input  logic                          pix_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned AW         = $clog2(FIFO_DEPTH);
    localparam int unsigned LW         = AW + 1;
    localparam int unsigned CW         = LW + 1;
    localparam int unsigned NUM_BURSTS = FRAME_WORDS / BURST_LEN;
    localparam int unsigned BCW        = $clog2(NUM_BURSTS) + 1;
    localparam int unsigned WCW        = $clog2(FRAME_WORDS) + 1;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_ROOM = 2'd1;
    localparam logic [1:0] REQ       = 2'd2;
    localparam logic [1:0] DRAIN     = 2'd3;

    logic [1:0]     state, state_nxt;
    logic [29:0]    addr_nxt;
    logic [BCW-1:0] bursts, bursts_nxt;
    logic [WCW-1:0] words, words_nxt;
    logic [LW-1:0]  outstanding, outstanding_nxt;
    logic           cool;
    logic           accept;
    logic           room_ok;
    logic           busy_nxt, read_nxt, done_nxt;

    assign ddr_burstcount = 8'(BURST_LEN);
    assign ddr_write      = 1'b0;
    assign ddr_writedata  = 32'h0;
    assign ddr_byteenable = 4'hF;

    // Requested-but-unreturned words count against FIFO space just like stored ones.
    assign room_ok = ({1'b0, fifo_level} + {1'b0, outstanding} + CW'(BURST_LEN)) <= CW'(FIFO_DEPTH);

    always_comb begin
        state_nxt  = state;
        addr_nxt   = ddr_address;
        bursts_nxt = bursts;
        words_nxt  = words + WCW'(ddr_readdatavalid);
        accept     = 1'b0;
        done_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    state_nxt  = WAIT_ROOM;
                    addr_nxt   = start_address & 30'h3FFF_FFFC;
                    bursts_nxt = '0;
                    words_nxt  = '0;
                end
            end
            WAIT_ROOM: begin
                // cool holds off one cycle after an accept so requests never run back to back
                if (!cool && room_ok) state_nxt = REQ;
            end
            REQ: begin
                if (!ddr_waitrequest) begin
                    accept     = 1'b1;
                    addr_nxt   = ddr_address + 30'(BURST_LEN * 4);
                    bursts_nxt = bursts + BCW'(1);
                    state_nxt  = (bursts == BCW'(NUM_BURSTS - 1)) ? DRAIN : WAIT_ROOM;
                end
            end
            DRAIN: begin
                done_nxt = ddr_readdatavalid && (words == WCW'(FRAME_WORDS - 1));
                if (words == WCW'(FRAME_WORDS)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        outstanding_nxt = outstanding + (accept ? LW'(BURST_LEN) : LW'(0)) - LW'(ddr_readdatavalid);
        busy_nxt        = (state_nxt != IDLE);
        read_nxt        = (state_nxt == REQ);
    end

    always_ff @(posedge clk_clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ddr_address <= '0;
            bursts      <= '0;
            words       <= '0;
            outstanding <= '0;
            cool        <= 1'b0;
            ddr_read    <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state       <= state_nxt;
            ddr_address <= addr_nxt;
            bursts      <= bursts_nxt;
            words       <= words_nxt;
            outstanding <= outstanding_nxt;
            cool        <= accept;
            ddr_read    <= read_nxt;
            busy        <= busy_nxt;
            frame_done  <= done_nxt;
        end
    end

    // Pixel FIFO: storage is unreset; head is masked to zero when empty.
    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push, pop;

    assign push      = ddr_readdatavalid;
    assign pop       = pix_valid && pix_ready;
    assign pix_valid = (fifo_level != '0);
    assign pix_data  = pix_valid ? mem[rd_ptr] : 32'h0;

    always_ff @(posedge clk_clk) begin
        if (push) mem[wr_ptr] <= ddr_readdata;
    end

    always_ff @(posedge clk_clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            fifo_level <= fifo_level + LW'(push) - LW'(pop);
        end
    end

endmodule

// File: tb/tb_fb_ddr_burst_reader.sv
// Bench for fb_ddr_burst_reader: random-data SDRAM slave, consumer and scoreboard,
// expected burst addresses computed arithmetically from the frame base.
module tb_fb_ddr_burst_reader;

    localparam int BL = 64;
    localparam int FW = 512;
    localparam int FD = 256;
    localparam int NB = FW / BL;

    logic        clk_clk = 1'b0;
    logic        reset;
    logic [29:0] start_address;
    logic        frame_start;
    logic        busy, frame_done;
    logic [29:0] ddr_address;
    logic [7:0]  ddr_burstcount;
    logic        ddr_read, ddr_write;
    logic [31:0] ddr_writedata;
    logic [3:0]  ddr_byteenable;
    logic        ddr_waitrequest;
    logic [31:0] ddr_readdata;
    logic        ddr_readdatavalid;
    logic [31:0] pix_data;
    logic        pix_valid, pix_ready;
    logic [8:0]  fifo_level;

    fb_ddr_burst_reader #(.BURST_LEN(BL), .FRAME_WORDS(FW), .FIFO_DEPTH(FD)) dut (
        .clk_clk(clk_clk), .reset(reset), .start_address(start_address),
        .frame_start(frame_start), .busy(busy), .frame_done(frame_done),
        .ddr_address(ddr_address), .ddr_burstcount(ddr_burstcount), .ddr_read(ddr_read),
        .ddr_write(ddr_write), .ddr_writedata(ddr_writedata), .ddr_byteenable(ddr_byteenable),
        .ddr_waitrequest(ddr_waitrequest), .ddr_readdata(ddr_readdata),
        .ddr_readdatavalid(ddr_readdatavalid), .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .fifo_level(fifo_level)
    );

    always #5 clk_clk = ~clk_clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] pend_q[$];
    logic [29:0] acc_addr[$];
    int   cyc = 0, done_neg = -10, last_set_neg = -100, done_lat = 0, done_cnt = 0;
    int   ret_cnt = 0, pix_cnt = 0, pix_err = 0, low_run = 0, min_gap = 1000;
    int   stall_burst = -1, stall_left = 0, stall_seen = 0, stall_viol = 0;
    int   ready_mode = 1, ready_left = 0;
    bit   gap_active = 0, stall_chk = 0, ovf = 0, lat_rand = 0;
    logic busy_after_done = 1'b1;
    logic [29:0] stall_addr;

    // Slave, consumer and event monitor; all decisions made on the falling edge.
    initial begin
        ddr_waitrequest = 1'b0; ddr_readdatavalid = 1'b0; ddr_readdata = '0; pix_ready = 1'b0;
        forever begin
            @(negedge clk_clk);
            cyc++;
            if (reset) begin
                ddr_waitrequest = 1'b0; ddr_readdatavalid = 1'b0; pix_ready = 1'b0;
                pend_q.delete(); exp_q.delete(); gap_active = 0; stall_chk = 0;
            end else begin
                if (cyc == done_neg + 1) busy_after_done = busy;
                if (frame_done) begin done_cnt++; done_neg = cyc; done_lat = cyc - last_set_neg; end
                if (stall_chk) begin
                    if (!ddr_read || ddr_address !== stall_addr) stall_viol++;
                    stall_chk = 0;
                end
                if (fifo_level > 9'(FD)) ovf = 1;
                if (ddr_read) begin
                    if (gap_active && low_run < min_gap) min_gap = low_run;
                    gap_active = 0;
                end else low_run++;
                case (ready_mode)
                    0: pix_ready = 1'b0;
                    2: pix_ready = 1'($urandom_range(0, 1));
                    3: begin pix_ready = (ready_left > 0); if (ready_left > 0) ready_left--; end
                    default: pix_ready = 1'b1;
                endcase
                if (pix_valid && pix_ready) begin
                    pix_cnt++;
                    if (exp_q.size() == 0) pix_err++;
                    else begin
                        if (pix_data !== exp_q[0]) pix_err++;
                        void'(exp_q.pop_front());
                    end
                end
                ddr_readdatavalid = 1'b0;
                if (pend_q.size() > 0 && (!lat_rand || $urandom_range(0, 3) != 0)) begin
                    ddr_readdatavalid = 1'b1;
                    ddr_readdata = pend_q.pop_front();
                    exp_q.push_back(ddr_readdata);
                    ret_cnt++;
                    if (ret_cnt == FW) last_set_neg = cyc;
                end
                ddr_waitrequest = 1'b0;
                if (ddr_read) begin
                    if ((acc_addr.size() == stall_burst && stall_left > 0) ||
                        (lat_rand && $urandom_range(0, 2) == 0)) begin
                        ddr_waitrequest = 1'b1;
                        if (acc_addr.size() == stall_burst && stall_left > 0) begin
                            stall_left--; stall_seen++;
                        end
                        stall_chk = 1; stall_addr = ddr_address;
                    end else begin
                        acc_addr.push_back(ddr_address);
                        for (int i = 0; i < BL; i++) pend_q.push_back($urandom);
                        gap_active = 1; low_run = 0;
                    end
                end
            end
        end
    end

    task automatic start_frame(input logic [29:0] base);
        @(negedge clk_clk); #1;
        acc_addr.delete(); ret_cnt = 0; done_cnt = 0; pix_cnt = 0; pix_err = 0;
        min_gap = 1000; done_neg = -10; last_set_neg = -100; busy_after_done = 1'b1;
        start_address = base; frame_start = 1'b1;
        @(negedge clk_clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic wait_frame(input int budget, output bit timed_out);
        timed_out = 1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_clk); #1;
            if (done_cnt > 0 && fifo_level == 9'd0 && exp_q.size() == 0 && pend_q.size() == 0) begin
                timed_out = 0;
                break;
            end
        end
        repeat (4) @(negedge clk_clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; frame_start = 1'b0; start_address = '0;
        repeat (3) @(negedge clk_clk);
        #1;
        total++; if ({ddr_read, busy, frame_done, pix_valid} !== 4'b0)
            begin bad++; $display("FAIL reset_ctrl: got %b want 0000", {ddr_read, busy, frame_done, pix_valid}); end
        total++; if (ddr_address !== 30'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", ddr_address); end
        total++; if (pix_data !== 32'h0) begin bad++; $display("FAIL reset_pix_data: got %h want 0", pix_data); end
        total++; if (fifo_level !== 9'h0) begin bad++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        total++; if (ddr_burstcount !== 8'd64) begin bad++; $display("FAIL burstcount: got %0d want 64", ddr_burstcount); end
        total++; if ({ddr_write, ddr_writedata} !== 33'h0)
            begin bad++; $display("FAIL write_const: got %b/%h want 0/0", ddr_write, ddr_writedata); end
        total++; if (ddr_byteenable !== 4'hF) begin bad++; $display("FAIL byteenable: got %h want F", ddr_byteenable); end
        reset = 1'b0;
        repeat (2) @(negedge clk_clk);
    endtask

    task automatic check_frame(input string name, input logic [29:0] base, input bit timed_out);
        logic [29:0] exp_a;
        logic [29:0] got_a;
        total++; if (timed_out) begin bad++; $display("FAIL %s_timeout: frame not finished within budget", name); end
        total++; if (acc_addr.size() != NB) begin bad++; $display("FAIL %s_bursts: got %0d want %0d", name, acc_addr.size(), NB); end
        for (int k = 0; k < NB; k++) begin
            exp_a = 30'((base & 30'h3FFF_FFFC) + 30'(k * BL * 4));
            got_a = (k < acc_addr.size()) ? acc_addr[k] : 30'bx;
            total++; if (got_a !== exp_a) begin bad++; $display("FAIL %s_addr%0d: got %h want %h", name, k, got_a, exp_a); end
        end
        total++; if (pix_cnt != FW || pix_err != 0)
            begin bad++; $display("FAIL %s_pixels: got %0d words %0d bad, want %0d words 0 bad", name, pix_cnt, pix_err, FW); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL %s_done_count: got %0d want 1", name, done_cnt); end
        total++; if (done_lat != 1) begin bad++; $display("FAIL %s_done_latency: got %0d want 1", name, done_lat); end
        total++; if (busy_after_done !== 1'b0) begin bad++; $display("FAIL %s_busy_drop: got %b want 0", name, busy_after_done); end
        total++; if (min_gap < 2) begin bad++; $display("FAIL %s_read_gap: got %0d want >=2", name, min_gap); end
        total++; if (ovf) begin bad++; $display("FAIL %s_overflow: got 1 want 0", name); end
    endtask

    task automatic test_single_frame;
        bit to;
        start_frame(30'h0100_0000);
        total++; if (busy !== 1'b1 || ddr_read !== 1'b0)
            begin bad++; $display("FAIL start_busy: got busy=%b read=%b want 1/0", busy, ddr_read); end
        @(negedge clk_clk); #1;
        total++; if (ddr_read !== 1'b1 || ddr_address !== 30'h0100_0000)
            begin bad++; $display("FAIL first_read: got %b@%h want 1@01000000", ddr_read, ddr_address); end
        wait_frame(5000, to);
        check_frame("single", 30'h0100_0000, to);
    endtask

    task automatic test_stall;
        bit to;
        logic [29:0] base;
        base = 30'($urandom);
        stall_burst = 1; stall_left = 7; stall_seen = 0; stall_viol = 0;
        start_frame(base);
        wait_frame(5000, to);
        check_frame("stall", base, to);
        total++; if (stall_seen != 7 || stall_viol != 0)
            begin bad++; $display("FAIL stall_hold: got %0d stalls %0d unstable, want 7 stalls 0 unstable", stall_seen, stall_viol); end
        stall_burst = -1;
    endtask

    task automatic test_backpressure;
        bit to;
        bit reached;
        int reads;
        ready_mode = 0;
        start_frame(30'h0004_0000);
        reached = 0;
        for (int i = 0; i < 3000 && !reached; i++) begin
            @(negedge clk_clk); #1;
            if (acc_addr.size() == 4 && fifo_level == 9'd256) reached = 1;
        end
        total++; if (!reached) begin bad++; $display("FAIL bp_fill: got level %0d bursts %0d want 256/4", fifo_level, acc_addr.size()); end
        reads = 0;
        for (int i = 0; i < 60; i++) begin @(negedge clk_clk); if (ddr_read) reads++; end
        total++; if (reads != 0 || fifo_level !== 9'd256 || acc_addr.size() != 4)
            begin bad++; $display("FAIL bp_hold: got reads=%0d level=%0d bursts=%0d want 0/256/4", reads, fifo_level, acc_addr.size()); end
        ready_left = 64; ready_mode = 3;
        repeat (200) @(negedge clk_clk);
        #1;
        total++; if (acc_addr.size() != 5 || fifo_level !== 9'd256)
            begin bad++; $display("FAIL bp_release: got bursts=%0d level=%0d want 5/256", acc_addr.size(), fifo_level); end
        ready_mode = 1;
        wait_frame(5000, to);
        check_frame("bp", 30'h0004_0000, to);
    endtask

    task automatic test_wrap;
        bit to;
        lat_rand = 1; ready_mode = 2;
        start_frame(30'h3FFF_FF00);
        wait_frame(20000, to);
        check_frame("wrap", 30'h3FFF_FF00, to);
        lat_rand = 0; ready_mode = 1;
    endtask

    task automatic test_busy_start;
        bit to;
        bit hit;
        start_frame(30'h0020_0000);
        for (int i = 0; i < 3000 && acc_addr.size() < 3; i++) @(negedge clk_clk);
        #1;
        start_address = 30'h1234_5600; frame_start = 1'b1;
        @(negedge clk_clk); #1;
        frame_start = 1'b0;
        hit = 0;
        for (int i = 0; i < 5000 && !hit; i++) begin
            @(negedge clk_clk);
            if (frame_done) begin
                hit = 1; #1; frame_start = 1'b1;
                @(negedge clk_clk); #1; frame_start = 1'b0;
            end
        end
        total++; if (!hit) begin bad++; $display("FAIL busy_start_done: frame_done never seen"); end
        wait_frame(2000, to);
        check_frame("busy_start", 30'h0020_0000, to);
        total++; if (busy !== 1'b0 || ddr_read !== 1'b0)
            begin bad++; $display("FAIL busy_start_idle: got busy=%b read=%b want 0/0", busy, ddr_read); end
    endtask

    task automatic test_reset_mid;
        bit to;
        bit hit;
        start_frame(30'h0080_0000);
        hit = 0;
        for (int i = 0; i < 3000 && !hit; i++) begin
            @(negedge clk_clk); #1;
            if (acc_addr.size() == 2 && ddr_read) hit = 1;
        end
        total++; if (!hit) begin bad++; $display("FAIL rst_mid_reach: burst 3 request never seen"); end
        #1; reset = 1'b1; #1;
        total++; if ({ddr_read, busy, frame_done, pix_valid} !== 4'b0 || ddr_address !== 30'h0 ||
                     pix_data !== 32'h0 || fifo_level !== 9'h0)
            begin bad++; $display("FAIL rst_mid_outputs: got ctrl=%b addr=%h data=%h level=%0d want all 0",
                                  {ddr_read, busy, frame_done, pix_valid}, ddr_address, pix_data, fifo_level); end
        repeat (3) @(negedge clk_clk);
        #2; reset = 1'b0;
        repeat (2) @(negedge clk_clk);
        start_frame(30'h0123_4567);
        wait_frame(5000, to);
        check_frame("after_reset", 30'h0123_4567, to);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_stall();
        test_backpressure();
        test_wrap();
        test_busy_start();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fb_ddr_burst_reader.md
# fb_ddr_burst_reader

Avalon-MM burst-read master that fetches one framebuffer from HPS DDR through the FPGA-to-SDRAM slave port (`ddr_*` of `soc_design`) and presents it as a 32-bit pixel stream. It is the read-side counterpart of the framebuffer write path. The base address comes from the `start_address` PIO export. An internal FIFO decouples DDR burst latency from the pixel consumer. The block never issues a burst unless the FIFO can absorb the whole burst, so `readdatavalid` is never back-pressured.

## Interface
- `BURST_LEN`, 64: words per burst; 1..128, power of 2.
- `FRAME_WORDS`, 307200: 32-bit words per frame; integer multiple of `BURST_LEN`.
- `FIFO_DEPTH`, 256: pixel FIFO depth; power of 2, at least 2*`BURST_LEN`.

Ports:
- `clk_clk`  in  1  system clock; same clock as the `soc_design` `ddr` port.
- `reset`  in  1  asynchronous, active-high reset.
- `start_address`  in  30  frame base byte address; bits [1:0] ignored (treated as 0).
- `frame_start`  in  1  one-cycle pulse that starts a frame fetch; ignored while `busy`.
- `busy`  out  1  frame fetch in progress.
- `frame_done`  out  1  one-cycle pulse when the last frame word enters the FIFO.
- `ddr_address`  out  30  burst byte address.
- `ddr_burstcount`  out  8  constant `BURST_LEN`.
- `ddr_read`  out  1  burst read request.
- `ddr_write`  out  1  constant 0.
- `ddr_writedata`  out  32  constant 0.
- `ddr_byteenable`  out  4  constant 4'hF.
- `ddr_waitrequest`  in  1  slave stall.
- `ddr_readdata`  in  32  read data.
- `ddr_readdatavalid`  in  1  read data qualifier.
- `pix_data`  out  32  FIFO head word.
- `pix_valid`  out  1  FIFO not empty.
- `pix_ready`  in  1  consumer accepts `pix_data` when `pix_valid`&`pix_ready`.
- `fifo_level`  out  log2(`FIFO_DEPTH`)+1  current FIFO occupancy.

## Operation
- States: `IDLE`, `WAIT_ROOM`, `REQ`, `DRAIN`.
- **IDLE**
  - On `frame_start`, latch {`start_address`[29:2],2'b00} into the address register and clear the issued-burst and received-word counters.
  - Go to `WAIT_ROOM`; `busy` is 1 from the next cycle.
- **WAIT_ROOM**
  - Credit is `FIFO_DEPTH` − `fifo_level` − `outstanding`, where `outstanding` is words requested but not yet returned.
  - If credit ≥ `BURST_LEN`, go to `REQ`.
- **REQ**
  - `ddr_read`=1 with address stable until the cycle where `ddr_waitrequest`=0 (accept).
  - On accept: `outstanding` += `BURST_LEN`; address += `BURST_LEN`*4, wrapping modulo 2^30; issued-burst count += 1.
  - If all `FRAME_WORDS`/`BURST_LEN` bursts are issued, go to `DRAIN`; otherwise go to `WAIT_ROOM`.
  - `ddr_read` is low for at least one cycle after each accept.
- **DRAIN**
  - Wait until the received-word count equals `FRAME_WORDS`.
  - Then pulse `frame_done`, go to `IDLE`, and drop `busy`.
- **Data return**, in any state:
  - Each `ddr_readdatavalid` writes `ddr_readdata` into the FIFO.
  - It also decrements `outstanding` and increments the received-word count.
  - The FIFO can never overflow by construction. Overflow is an assertion failure in verification.
- **FIFO**
  - Show-ahead: `pix_data` is the head word whenever `pix_valid`=1.
  - A simultaneous push and pop leaves `fifo_level` unchanged.
  - The FIFO keeps draining after `frame_done`.
- **Frame starts while busy:** a `frame_start` while `busy`=1 is dropped with no effect. A `frame_start` in the same cycle as the `frame_done` transition is also dropped.
- **Reset**
  - Any `reset` returns all state to `IDLE` immediately and empties the FIFO.
  - Bursts in flight at reset are not tracked. The system must not deassert `reset` while the SDRAM port still returns data.

## Timing
- Values held during reset: `ddr_read`=0, `ddr_address`=0, `busy`=0, `frame_done`=0, `pix_valid`=0, `pix_data`=0, `fifo_level`=0. Constants (`ddr_burstcount`, `ddr_write`, `ddr_writedata`, `ddr_byteenable`) hold their fixed values.
- All outputs are registered, except `pix_data`/`pix_valid`, which are driven from FIFO state registers.
- `frame_start` at cycle N:
  - `busy`=1 at N+1.
  - Earliest `ddr_read`=1 is at N+2 (entry to `WAIT_ROOM` at N+1, `REQ` at N+2).
- Accept at cycle A: `ddr_read`=0 at A+1; the next `ddr_read` is at A+3 at the earliest.
- `ddr_readdatavalid` at cycle R: `pix_valid`=1 and `fifo_level` updated at R+1.
- Last word's `readdatavalid` at cycle L: `frame_done`=1 at L+1 and `busy`=0 at L+2.

## Test plan
- **Single frame, zero latency:** `FRAME_WORDS`=256, `BURST_LEN`=64, `start_address`=0x0100_0000.
  - Slave model returns incrementing data with no waitrequest; `pix_ready`=1.
  - Required: 4 bursts at 0x0100_0000, 0x0100_0100, 0x0100_0200, 0x0100_0300; 256 words out in order; one `frame_done` pulse.
- **Waitrequest stall:** hold `ddr_waitrequest`=1 for 7 cycles on burst 2.
  - Required: `ddr_address`/`ddr_read` stable throughout; exactly one accept; no duplicate burst.
- **Back-pressure:** `pix_ready`=0 for the whole frame.
  - Required: after 4 bursts, `fifo_level`=256 and `ddr_read` stays 0.
  - Raising `pix_ready` for 64 cycles triggers exactly one new burst.
- **Address wrap:** `start_address`=0x3FFF_FF00, 2 bursts.
  - Required: second burst address is 0x0000_0000.
- **Frame start while busy:** `frame_start` pulsed mid-frame and again in the `frame_done` cycle.
  - Required: both ignored; burst count unchanged.
- **Reset mid-frame:** assert `reset` during burst 3, with no further data returned after release.
  - Required: all outputs at reset values; a new `frame_start` then fetches a full frame correctly.
